// File: rtl/mmio_responder.sv
// Memory-mapped peripheral responder for the multi-cycle CPU data bus.
// Provides GPIO, an edge latch, a down-counting timer, an output FIFO and an IRQ block.
module mmio_responder #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] MMIO_BASE  = 16'hFFF0,
  parameter int               FIFO_DEPTH = 4,
  parameter int               GPIN_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  i_mem_addr,
  input  logic [WIDTH-1:0]  i_mem_wdata,
  input  logic              i_mem_write,
  input  logic              i_mem_read,
  output logic              o_ram_sel,
  output logic [WIDTH-1:0]  o_mem_rdata,
  input  logic [GPIN_W-1:0] i_gpio_in,
  output logic [WIDTH-1:0]  o_gpio_out,
  output logic [WIDTH-1:0]  o_fifo_dout,
  output logic              o_fifo_valid,
  input  logic              i_fifo_ready,
  output logic              o_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0]  w_off;
  logic [3:0]        w_idx;
  logic              w_in_win;
  logic              w_wr_en;
  logic              w_wr_gpo;
  logic              w_wr_edge;
  logic              w_wr_tld;
  logic              w_wr_tctl;
  logic              w_wr_fdata;
  logic              w_wr_fstat;
  logic              w_wr_istat;
  logic              w_wr_ien;
  logic [WIDTH-1:0]  w_rd_val;

  logic [WIDTH-1:0]  r_gpio_out;
  logic [WIDTH-1:0]  r_rdata;
  logic [GPIN_W-1:0] r_sync1;
  logic [GPIN_W-1:0] r_sync2;
  logic [GPIN_W-1:0] r_sync3;
  logic [GPIN_W-1:0] r_edge;
  logic [GPIN_W-1:0] w_rise;
  logic [GPIN_W-1:0] w_edge_clr;

  logic [WIDTH-1:0]  r_tmr_load;
  logic [WIDTH-1:0]  r_tmr_count;
  logic              r_tmr_en;
  logic              r_tmr_ar;
  logic              w_tmr_expire;

  logic [1:0]        r_irq_stat;
  logic [1:0]        r_irq_en;
  logic [1:0]        w_irq_set;
  logic [1:0]        w_irq_clr;

  logic [WIDTH-1:0]  r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_fifo_cnt;
  logic              r_fifo_ovf;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_push_drop;
  logic [2:0]        w_cnt3;

  // Address decode: window offset and per-register write strobes
  assign o_ram_sel  = (i_mem_addr < MMIO_BASE);
  assign w_off      = i_mem_addr - MMIO_BASE;
  assign w_idx      = w_off[3:0];
  assign w_in_win   = !o_ram_sel && (w_off[WIDTH-1:4] == '0);
  assign w_wr_en    = i_mem_write && w_in_win;
  assign w_wr_gpo   = w_wr_en && (w_idx == 4'd0);
  assign w_wr_edge  = w_wr_en && (w_idx == 4'd2);
  assign w_wr_tld   = w_wr_en && (w_idx == 4'd3);
  assign w_wr_tctl  = w_wr_en && (w_idx == 4'd5);
  assign w_wr_fdata = w_wr_en && (w_idx == 4'd6);
  assign w_wr_fstat = w_wr_en && (w_idx == 4'd7);
  assign w_wr_istat = w_wr_en && (w_idx == 4'd8);
  assign w_wr_ien   = w_wr_en && (w_idx == 4'd9);

  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_edge_clr = w_wr_edge ? i_mem_wdata[GPIN_W-1:0] : '0;

  assign w_fifo_full  = (r_fifo_cnt == CW'(FIFO_DEPTH));
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_pop        = !w_fifo_empty && i_fifo_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push_ok    = w_wr_fdata && (!w_fifo_full || w_pop);
  assign w_push_drop  = w_wr_fdata && w_fifo_full && !w_pop;
  assign w_cnt3       = 3'(r_fifo_cnt);

  assign w_irq_set  = {(|r_edge), w_tmr_expire};
  assign w_irq_clr  = w_wr_istat ? i_mem_wdata[1:0] : 2'b00;

  assign o_mem_rdata  = r_rdata;
  assign o_gpio_out   = r_gpio_out;
  assign o_fifo_dout  = r_fifo_mem[r_rd_ptr];
  assign o_fifo_valid = !w_fifo_empty;
  assign o_irq        = |(r_irq_stat & r_irq_en);

  // Timer expiry fires only on a genuine 1->0 step not overridden by a reload write
  always_comb begin
    w_tmr_expire = 1'b0;
    if (r_tmr_en && !w_wr_tld && (r_tmr_count == WIDTH'(1))) begin
      w_tmr_expire = 1'b1;
    end else begin
      w_tmr_expire = 1'b0;
    end
  end

  // Register read multiplexer
  always_comb begin
    w_rd_val = '0;
    if (w_in_win) begin
      case (w_idx)
        4'd0:    w_rd_val = r_gpio_out;
        4'd1:    w_rd_val = {{(WIDTH-GPIN_W){1'b0}}, r_sync2};
        4'd2:    w_rd_val = {{(WIDTH-GPIN_W){1'b0}}, r_edge};
        4'd3:    w_rd_val = r_tmr_load;
        4'd4:    w_rd_val = r_tmr_count;
        4'd5:    w_rd_val = {{(WIDTH-2){1'b0}}, r_tmr_ar, r_tmr_en};
        4'd7:    w_rd_val = {{(WIDTH-6){1'b0}}, r_fifo_ovf, w_cnt3, w_fifo_empty, w_fifo_full};
        4'd8:    w_rd_val = {{(WIDTH-2){1'b0}}, r_irq_stat};
        4'd9:    w_rd_val = {{(WIDTH-2){1'b0}}, r_irq_en};
        default: w_rd_val = '0;
      endcase
    end else begin
      w_rd_val = '0;
    end
  end

  // Read data capture, GPIO output and IRQ registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata    <= '0;
      r_gpio_out <= '0;
      r_irq_stat <= 2'b00;
      r_irq_en   <= 2'b00;
    end else begin
      if (i_mem_read) begin
        r_rdata <= o_ram_sel ? '0 : w_rd_val;
      end
      if (w_wr_gpo) begin
        r_gpio_out <= i_mem_wdata;
      end
      if (w_wr_ien) begin
        r_irq_en <= i_mem_wdata[1:0];
      end
      r_irq_stat <= (r_irq_stat & ~w_irq_clr) | w_irq_set;
    end
  end

  // Input synchronizer and rising-edge latch; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= i_gpio_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= (r_edge & ~w_edge_clr) | w_rise;
    end
  end

  // Down-counting timer; a TMR_LOAD write takes priority over the decrement
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tmr_load  <= '0;
      r_tmr_count <= '0;
      r_tmr_en    <= 1'b0;
      r_tmr_ar    <= 1'b0;
    end else begin
      if (w_wr_tld) begin
        r_tmr_load  <= i_mem_wdata;
        r_tmr_count <= i_mem_wdata;
      end else if (r_tmr_en) begin
        if (r_tmr_count != '0) begin
          r_tmr_count <= r_tmr_count - WIDTH'(1);
        end else if (r_tmr_ar) begin
          r_tmr_count <= r_tmr_load;
        end
      end
      if (w_wr_tctl) begin
        r_tmr_en <= i_mem_wdata[0];
        r_tmr_ar <= i_mem_wdata[1];
      end else if (r_tmr_en && !r_tmr_ar && !w_wr_tld && (r_tmr_count == '0)) begin
        r_tmr_en <= 1'b0;
      end
    end
  end

  // Output FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_fifo_ovf <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_fifo_mem[r_wr_ptr] <= i_mem_wdata;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_wr_fstat) begin
        r_fifo_ovf <= 1'b0;
      end else if (w_push_drop) begin
        r_fifo_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed test of mmio_responder: register map, edge latch, timer modes, FIFO and reset.
module tb_mmio_responder;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic        ram_sel;
  logic [15:0] mem_rdata;
  logic [7:0]  gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] fifo_dout;
  logic        fifo_valid;
  logic        fifo_ready;
  logic        irq;

  int n_cmp;
  int n_bad;

  mmio_responder dut (
    .clk          (clk),
    .reset        (reset),
    .i_mem_addr   (mem_addr),
    .i_mem_wdata  (mem_wdata),
    .i_mem_write  (mem_write),
    .i_mem_read   (mem_read),
    .o_ram_sel    (ram_sel),
    .o_mem_rdata  (mem_rdata),
    .i_gpio_in    (gpio_in),
    .o_gpio_out   (gpio_out),
    .o_fifo_dout  (fifo_dout),
    .o_fifo_valid (fifo_valid),
    .i_fifo_ready (fifo_ready),
    .o_irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_write = 1'b1;
    cyc();
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    mem_addr = a;
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    check_eq(tag, {16'h0000, mem_rdata}, {16'h0000, exp});
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    clk        = 1'b0;
    reset      = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    gpio_in    = 8'h00;
    fifo_ready = 1'b0;

    cyc();
    cyc();
    check_eq("rst_rdata",   {16'h0000, mem_rdata},  32'h0);
    check_eq("rst_gpo",     {16'h0000, gpio_out},   32'h0);
    check_eq("rst_valid",   {31'h0, fifo_valid},    32'h0);
    check_eq("rst_irq",     {31'h0, irq},           32'h0);
    check_eq("rst_ramsel",  {31'h0, ram_sel},       32'h1);
    reset = 1'b1;
    cyc();

    // GPIO output store/load
    wr(16'hFFF0, 16'hA5A5);
    check_eq("gpo_out",    {16'h0000, gpio_out}, 32'h0000A5A5);
    check_eq("gpo_ramsel", {31'h0, ram_sel},     32'h0);
    rd(16'hFFF0, 16'hA5A5, "gpo_rd");
    rd(16'hFFFA, 16'h0000, "reserved_rd");

    // Synchronized input and edge latch
    gpio_in = 8'h81;
    cyc(); cyc(); cyc();
    rd(16'hFFF1, 16'h0081, "gpin_rd");
    rd(16'hFFF2, 16'h0081, "edge_rd");
    wr(16'hFFF2, 16'h0001);
    rd(16'hFFF2, 16'h0080, "edge_w1c");
    gpio_in = 8'h80;
    cyc(); cyc(); cyc();
    gpio_in = 8'h81;
    cyc(); cyc();
    wr(16'hFFF2, 16'h0001);
    rd(16'hFFF2, 16'h0081, "edge_set_wins");
    wr(16'hFFF2, 16'h00FF);
    wr(16'hFFF8, 16'h0003);
    rd(16'hFFF8, 16'h0000, "istat_clr");

    // Timer with autoreload
    wr(16'hFFF9, 16'h0001);
    wr(16'hFFF3, 16'h0003);
    wr(16'hFFF5, 16'h0003);
    rd(16'hFFF4, 16'h0003, "tmr_ar_3");
    rd(16'hFFF4, 16'h0002, "tmr_ar_2");
    rd(16'hFFF4, 16'h0001, "tmr_ar_1");
    check_eq("tmr_ar_irq", {31'h0, irq}, 32'h1);
    rd(16'hFFF4, 16'h0000, "tmr_ar_0");
    rd(16'hFFF4, 16'h0003, "tmr_ar_reload");
    wr(16'hFFF5, 16'h0000);
    wr(16'hFFF8, 16'h0001);
    check_eq("tmr_irq_clr", {31'h0, irq}, 32'h0);

    // Timer one-shot
    wr(16'hFFF3, 16'h0003);
    wr(16'hFFF5, 16'h0001);
    rd(16'hFFF4, 16'h0003, "tmr_os_3");
    rd(16'hFFF4, 16'h0002, "tmr_os_2");
    rd(16'hFFF4, 16'h0001, "tmr_os_1");
    rd(16'hFFF4, 16'h0000, "tmr_os_0");
    rd(16'hFFF5, 16'h0000, "tmr_os_ctrl");
    rd(16'hFFF4, 16'h0000, "tmr_os_hold");
    check_eq("tmr_os_irq", {31'h0, irq}, 32'h1);
    wr(16'hFFF8, 16'h0001);
    check_eq("tmr_os_irqclr", {31'h0, irq}, 32'h0);

    // FIFO overflow and drain
    for (int i = 1; i <= 5; i++) begin
      wr(16'hFFF6, 16'(i));
    end
    rd(16'hFFF7, 16'h0031, "fifo_stat_ovf");
    check_eq("fifo_valid_full", {31'h0, fifo_valid}, 32'h1);
    fifo_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("fifo_pop_order", {16'h0000, fifo_dout}, 32'(k));
      cyc();
    end
    check_eq("fifo_drained", {31'h0, fifo_valid}, 32'h0);
    fifo_ready = 1'b0;
    wr(16'hFFF7, 16'h0000);
    rd(16'hFFF7, 16'h0002, "fifo_ovf_clr");

    // Push while full with a simultaneous pop
    for (int i = 0; i < 4; i++) begin
      wr(16'hFFF6, 16'h0010 + 16'(i));
    end
    fifo_ready = 1'b1;
    wr(16'hFFF6, 16'h0014);
    fifo_ready = 1'b0;
    rd(16'hFFF7, 16'h0011, "fifo_full_pushpop");
    check_eq("fifo_head_after", {16'h0000, fifo_dout}, 32'h11);
    fifo_ready = 1'b1;
    cyc(); cyc(); cyc();
    check_eq("fifo_new_word", {16'h0000, fifo_dout}, 32'h14);
    cyc();
    check_eq("fifo_empty2", {31'h0, fifo_valid}, 32'h0);
    fifo_ready = 1'b0;

    // Reset in the middle of activity
    wr(16'hFFF9, 16'h0001);
    wr(16'hFFF3, 16'h0050);
    wr(16'hFFF5, 16'h0001);
    wr(16'hFFF6, 16'h00AA);
    wr(16'hFFF6, 16'h00BB);
    rd(16'hFFF0, 16'hA5A5, "pre_rst_rd");
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check_eq("mid_rst_gpo",   {16'h0000, gpio_out},  32'h0);
    check_eq("mid_rst_rdata", {16'h0000, mem_rdata}, 32'h0);
    check_eq("mid_rst_valid", {31'h0, fifo_valid},   32'h0);
    check_eq("mid_rst_dout",  {16'h0000, fifo_dout}, 32'h0);
    check_eq("mid_rst_irq",   {31'h0, irq},          32'h0);
    rd(16'hFFF0, 16'h0000, "post_rst_gpo");
    wr(16'hFFF0, 16'h1234);
    rd(16'h0100, 16'h0000, "ram_rd");
    check_eq("ram_sel_hi", {31'h0, ram_sel}, 32'h1);
    rd(16'hFFF4, 16'h0000, "post_rst_count");
    rd(16'hFFF5, 16'h0000, "post_rst_ctrl");
    rd(16'hFFF7, 16'h0002, "post_rst_fstat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
